// File: rtl/argmax_stream_if.sv
// Score-stream in / argmax-result out bundle for argmax_stream; ARGMAX_TOP2_EN adds the runner-up fields.
// slave = argmax block side, master = the driving/consuming environment.
interface argmax_stream_if #(
  parameter int M = 10,
  parameter int T = 16
);
  localparam int IW = $clog2(M);

  logic                input_valid;
  logic                input_ready;
  logic signed [T-1:0] input_data;
  logic                output_valid;
  logic                output_ready;
  logic [IW-1:0]       output_index;
  logic signed [T-1:0] output_value;
`ifdef ARGMAX_TOP2_EN
  logic [IW-1:0]       output_index2;
  logic signed [T-1:0] output_value2;
`endif

  modport slave (
    input  input_valid, input_data, output_ready,
    output input_ready, output_valid, output_index, output_value
`ifdef ARGMAX_TOP2_EN
    , output output_index2, output_value2
`endif
  );

  modport master (
    output input_valid, input_data, output_ready,
    input  input_ready, output_valid, output_index, output_value
`ifdef ARGMAX_TOP2_EN
    , input output_index2, output_value2
`endif
  );
endinterface

// File: rtl/argmax_stream.sv
// Streaming argmax over M signed scores; result valid the cycle after the M-th accept, held until taken.
// input_ready is 0 while a result waits (any output_ready stall); ARGMAX_TOP2_EN adds runner-up outputs.
module argmax_stream #(
  parameter int M = 10,
  parameter int T = 16
) (
  input logic          clk,
  input logic          reset,
  argmax_stream_if.slave bus
);
  localparam int IW = $clog2(M);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t              state, state_nxt;
  logic                live;
  logic [IW-1:0]       cnt;
  logic signed [T-1:0] max_q;
  logic [IW-1:0]       idx_q;
  logic                acc, rel_acc, last, gt_max;

  assign acc     = bus.input_valid && bus.input_ready;
  assign rel_acc = bus.output_valid && bus.output_ready;
  assign last    = (cnt == IW'(M - 1));
  assign gt_max  = (bus.input_data > max_q);

  always_ff @(posedge clk) begin
    if (!reset) state <= ACCUM;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (acc && last) state_nxt = HOLD;
      HOLD:    if (rel_acc)     state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // live keeps both handshake outputs low for the whole reset cycle
  always_comb begin
    bus.input_ready  = live && (state == ACCUM);
    bus.output_valid = live && (state == HOLD);
  end

  always_ff @(posedge clk) begin
    if (!reset) live <= 1'b0;
    else        live <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt   <= '0;
      max_q <= '0;
      idx_q <= '0;
    end else if (acc) begin
      cnt <= last ? '0 : cnt + IW'(1);
      if (cnt == '0) begin
        max_q <= bus.input_data;
        idx_q <= '0;
      end else if (gt_max) begin
        max_q <= bus.input_data;
        idx_q <= cnt;
      end
    end
  end

  assign bus.output_index = idx_q;
  assign bus.output_value = max_q;

`ifdef ARGMAX_TOP2_EN
  logic                sec_vld;
  logic signed [T-1:0] sec_q;
  logic [IW-1:0]       sec_idx_q;

  // an element equal to the current max falls through to the runner-up slot
  always_ff @(posedge clk) begin
    if (!reset) begin
      sec_vld   <= 1'b0;
      sec_q     <= '0;
      sec_idx_q <= '0;
    end else if (acc) begin
      if (cnt == '0) begin
        sec_vld <= 1'b0;
      end else if (gt_max) begin
        sec_vld   <= 1'b1;
        sec_q     <= max_q;
        sec_idx_q <= idx_q;
      end else if (!sec_vld || (bus.input_data > sec_q)) begin
        sec_vld   <= 1'b1;
        sec_q     <= bus.input_data;
        sec_idx_q <= cnt;
      end
    end
  end

  assign bus.output_index2 = sec_idx_q;
  assign bus.output_value2 = sec_q;
`endif
endmodule
